// File: rtl/dmux_rr_dispatcher_pkg.sv
// Shared lane definitions and holding-register state encoding for the
// round-robin 1-to-4 dispatcher.
package dmux_rr_dispatcher_pkg;
  localparam int NUM_LANES = 4;
  localparam int SEL_W     = 2;

  typedef logic [SEL_W-1:0] lane_sel_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } hold_state_e;
endpackage

// File: rtl/dmux_rr_dispatcher_dmux_1to4.sv
// Combinational 1-to-4 demux: raises the valid of the lane selected by
// hold_sel, or no lane at all while the holding register is empty.
module dmux_1to4
  import dmux_rr_dispatcher_pkg::*;
(
  input  logic                 hold_valid,
  input  lane_sel_t            hold_sel,
  output logic [NUM_LANES-1:0] out_valid
);

  always_comb begin
    out_valid = '0;
    if (hold_valid) out_valid[hold_sel] = 1'b1;
  end

endmodule

// File: rtl/dmux_rr_dispatcher.sv
// Round-robin dispatcher: one-deep holding register feeding four lanes on a
// shared data bus, with per-lane credit counters replenished by DONE pulses.
module dmux_rr_dispatcher
  import dmux_rr_dispatcher_pkg::*;
#(
  parameter int DW      = 8,
  parameter int CREDITS = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [DW-1:0]        IN_DATA,
  input  logic [NUM_LANES-1:0] LANE_EN,
  output logic [NUM_LANES-1:0] OUT_VALID,
  input  logic [NUM_LANES-1:0] OUT_READY,
  output logic [DW-1:0]        OUT_DATA,
  input  logic [NUM_LANES-1:0] DONE,
  output logic                 ERR
);

  localparam int             CW       = $clog2(CREDITS + 1);
  localparam logic [CW-1:0]  CRED_MAX = CW'(CREDITS);

  hold_state_e                   state_q, state_d;
  lane_sel_t                     hold_sel_q, hold_sel_d;
  lane_sel_t                     ptr_q, ptr_d;
  logic [DW-1:0]                 hold_data_q, hold_data_d;
  logic [NUM_LANES-1:0][CW-1:0]  credit_q, credit_d;
  logic                          err_q, err_d;

  logic [NUM_LANES-1:0] eligible, rot;
  lane_sel_t            offs, sel;
  logic                 hold_valid, out_fire, accept, consume;

  // Rotate eligibility so ptr sits at bit 0, take the lowest set bit, then
  // rotate the offset back into an absolute lane number.
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      eligible[i] = LANE_EN[i] & (credit_q[i] != '0);
    end
    rot = '0;
    for (int j = 0; j < NUM_LANES; j++) begin
      rot[j] = eligible[lane_sel_t'(ptr_q + lane_sel_t'(j))];
    end
    offs = '0;
    for (int j = NUM_LANES - 1; j >= 0; j--) begin
      if (rot[j]) offs = lane_sel_t'(j);
    end
    sel = ptr_q + offs;
  end

  assign hold_valid = (state_q == FULL);
  assign out_fire   = hold_valid & OUT_READY[hold_sel_q];
  assign IN_READY   = (~hold_valid | out_fire) & (|eligible);
  assign accept     = IN_VALID & IN_READY;

  always_comb begin
    state_d     = state_q;
    hold_sel_d  = hold_sel_q;
    hold_data_d = hold_data_q;
    ptr_d       = ptr_q;
    if (accept) begin
      state_d     = FULL;
      hold_sel_d  = sel;
      hold_data_d = IN_DATA;
      ptr_d       = sel + lane_sel_t'(1);
    end else if (out_fire) begin
      state_d = EMPTY;
    end
  end

  // A consume and a return on the same lane cancel; a return to a full
  // counter is dropped and flagged.
  always_comb begin
    credit_d = credit_q;
    err_d    = err_q;
    consume  = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      consume = accept & (sel == lane_sel_t'(i));
      if (DONE[i] && !consume) begin
        if (credit_q[i] == CRED_MAX) err_d = 1'b1;
        else                         credit_d[i] = credit_q[i] + CW'(1);
      end else if (consume && !DONE[i]) begin
        credit_d[i] = credit_q[i] - CW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= EMPTY;
      hold_sel_q  <= '0;
      hold_data_q <= '0;
      ptr_q       <= '0;
      err_q       <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) credit_q[i] <= CRED_MAX;
    end else begin
      state_q     <= state_d;
      hold_sel_q  <= hold_sel_d;
      hold_data_q <= hold_data_d;
      ptr_q       <= ptr_d;
      err_q       <= err_d;
      credit_q    <= credit_d;
    end
  end

  dmux_1to4 u_dmux (
    .hold_valid (hold_valid),
    .hold_sel   (hold_sel_q),
    .out_valid  (OUT_VALID)
  );

  assign OUT_DATA = hold_data_q;
  assign ERR      = err_q;

endmodule
